// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and sizing/clamp helpers for the serial pattern detector
package seq_det_pkg;
  localparam int DEF_LEN_C = 5;
  localparam logic [7:0] DEF_PATTERN_C = 8'b10010;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  function automatic int clamp_len(input int len, input int max_len);
    return len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: configuration, stream and status signals of the pattern detector
interface seq_detector_param_if import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = len_w(MAX_LEN);
  logic cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
  logic cnt_clr;
  logic in_valid;
  logic a;
  logic z;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] cstate;
  logic cfg_err;
  modport master(
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, a,
    input z, match_cnt, cstate, cfg_err
  );
  modport slave(
    input cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, a,
    output z, match_cnt, cstate, cfg_err
  );
endinterface

// File: rtl/seq_window_cmp.sv
// seq_window_cmp: finds which pattern prefixes end the stored history; pre_o means one more correct bit completes a match
module seq_window_cmp import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] hist_i,
  input  logic [LEN_W-1:0]   fill_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  output logic               pre_o,
  output logic [LEN_W-1:0]   prog_o
);
  logic [MAX_LEN-1:0] m;
  assign m[0] = 1'b1;
  // m[k]: newest k history bits equal the first k pattern bits (pattern[len-1 -: k])
  for (genvar k = 1; k < MAX_LEN; k++) begin : g_k
    localparam logic [MAX_LEN-1:0] MSK = MAX_LEN'((1 << k) - 1);
    assign m[k] = (LEN_W'(k) <= fill_i) &&
                  ((((pattern_i >> (len_i - LEN_W'(k))) ^ {1'b0, hist_i}) & MSK) == '0);
  end
  always_comb begin
    pre_o = 1'b0;
    prog_o = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (m[i] && LEN_W'(i) < len_i) prog_o = LEN_W'(i);
      if (LEN_W'(i + 1) == len_i) pre_o = m[i];
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with match pulse, saturating count and progress
module seq_detector_param import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int DEF_LEN = DEF_LEN_C,
  parameter bit DEF_OVERLAP = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave s
);
  localparam int LEN_W = len_w(MAX_LEN);
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, prog;
  logic ovl_q, ovl_d, z_q, z_d, err_q, err_d, pre, hit;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_window_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_cmp (
    .hist_i(hist_q),
    .fill_i(fill_q),
    .len_i(len_q),
    .pattern_i(pat_q),
    .pre_o(pre),
    .prog_o(prog)
  );
  // a match completes when the stored prefix of length len-1 is followed by the last pattern bit
  assign hit = s.in_valid && !s.cfg_load && pre && (s.a == pat_q[0]);
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    err_d = err_q;
    z_d = hit;
    cnt_d = s.cnt_clr ? CNT_W'(hit) : cnt_q + CNT_W'(hit && cnt_q != '1);
    if (s.cfg_load) begin
      pat_d = s.cfg_pattern;
      len_d = LEN_W'(clamp_len(int'(s.cfg_len), MAX_LEN));
      ovl_d = s.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      err_d = s.cfg_len == '0 || int'(s.cfg_len) > MAX_LEN;
    end else if (s.in_valid) begin
      hist_d = (MAX_LEN-1)'({hist_q, s.a});
      fill_d = (hit && !ovl_q) ? '0 : fill_q == LEN_W'(MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= DEF_PATTERN;
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      z_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q <= z_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign s.z = z_q;
  assign s.match_cnt = cnt_q;
  assign s.cstate = prog;
  assign s.cfg_err = err_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random stimulus against a bit-queue reference model
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) m();
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) n();
  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .s(m.slave));
  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .s(n.slave));
  assign n.cfg_load = m.cfg_load;
  assign n.cfg_pattern = m.cfg_pattern;
  assign n.cfg_len = m.cfg_len;
  assign n.cfg_overlap = m.cfg_overlap;
  assign n.cnt_clr = m.cnt_clr;
  assign n.in_valid = m.in_valid;
  assign n.a = m.a;
  bit [7:0] m_pat;
  int m_len, m_c8, m_c2;
  bit m_ovl, m_err, m_z;
  bit bits[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // true when the newest k stream bits spell the first k pattern bits
  function automatic bit sfx(input int k);
    if (k > bits.size()) return 1'b0;
    for (int i = 0; i < k; i++)
      if (bits[bits.size() - k + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int exp_cs();
    int best = 0;
    for (int k = 1; k < m_len; k++) if (sfx(k)) best = k;
    return best;
  endfunction
  task automatic cyc(input bit r, input bit ld, input logic [7:0] p, input int l, input bit o,
                     input bit clr, input bit v, input bit av);
    bit hit = 1'b0;
    rst = r;
    m.cfg_load = ld;
    m.cfg_pattern = p;
    m.cfg_len = 4'(l);
    m.cfg_overlap = o;
    m.cnt_clr = clr;
    m.in_valid = v;
    m.a = av;
    @(posedge clk);
    if (r) begin
      m_pat = 8'b10010; m_len = 5; m_ovl = 1'b1; m_err = 1'b0;
      bits.delete(); m_c8 = 0; m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = p; m_len = l > 8 ? 8 : l; m_ovl = o; m_err = (l == 0 || l > 8);
        bits.delete();
      end else if (v) begin
        bits.push_back(av);
        if (bits.size() > 8) void'(bits.pop_front());
        hit = m_len > 0 && sfx(m_len);
        if (hit && !m_ovl) bits.delete();
      end
      if (clr) begin
        m_c8 = int'(hit); m_c2 = int'(hit);
      end else if (hit) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    m_z = hit;
    #1;
    chk("z", int'(m.z), int'(m_z));
    chk("match_cnt", int'(m.match_cnt), m_c8);
    chk("match_cnt_w2", int'(n.match_cnt), m_c2);
    chk("cstate", int'(m.cstate), exp_cs());
    chk("cfg_err", int'(m.cfg_err), int'(m_err));
  endtask
  task automatic bit_in(input bit av);
    cyc(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, av);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic load(input logic [7:0] p, input int l, input bit o);
    cyc(1'b0, 1'b1, p, l, o, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic stream(input logic [7:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) bit_in(s[i]);
  endtask
  initial begin
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    stream(8'b10010010, 8);
    chk("t1_cnt", int'(m.match_cnt), 2);
    load(8'b10010, 5, 1'b0);
    stream(8'b10010010, 8);
    chk("t2_cnt", int'(m.match_cnt), 3);
    load(8'b111, 3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b1);
      idle();
    end
    chk("t3_cnt", int'(m.match_cnt), 7);
    load(8'h00, 0, 1'b1);
    chk("t4_err0", int'(m.cfg_err), 1);
    stream(8'h00, 8);
    load(8'hA5, 9, 1'b1);
    chk("t4_err9", int'(m.cfg_err), 1);
    stream(8'hA5, 8);
    chk("t4_len8_cnt", int'(m.match_cnt), 8);
    load(8'b1011, 4, 1'b1);
    chk("t4_err_clr", int'(m.cfg_err), 0);
    load(8'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1'b1);
    chk("t5_sat", int'(n.match_cnt), 3);
    cyc(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_hit", int'(n.match_cnt), 1);
    load(8'b10010, 5, 1'b1);
    stream(8'b1001, 4);
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_cs", int'(m.cstate), 0);
    bit_in(1'b0);
    chk("t6_rst_z", int'(m.z), 0);
    stream(8'b1001, 4);
    load(8'b10010, 5, 1'b1);
    chk("t6_ld_cs", int'(m.cstate), 0);
    bit_in(1'b0);
    chk("t6_ld_z", int'(m.z), 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(63) == 0, $urandom_range(15) == 0, 8'($urandom), int'($urandom_range(10)),
          1'($urandom), $urandom_range(19) == 0, $urandom_range(3) != 0, 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
